// File: rtl/mips_fwd_ctrl.sv
// Forwarding and load-use hazard controller for a 5-stage MIPS pipeline.
// Tracks destination registers of the instructions in EX and MEM, produces
// registered ALU operand-select codes for the instruction entering EX, and a
// combinational load-use stall for the instruction sitting in ID.
module mips_fwd_ctrl #(
    parameter logic [5:0] ALUOP  = 6'd0,
    parameter logic [5:0] LWOP   = 6'd35,
    parameter logic [5:0] SWOP   = 6'd43,
    parameter logic [5:0] ADDIOP = 6'd8,
    parameter logic [5:0] JOP    = 6'd2,
    parameter logic [5:0] JALOP  = 6'd3
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       id_valid,
    input  logic [5:0] id_op,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic [4:0] id_rd,
    input  logic       id_flush,
    output logic [1:0] fa,
    output logic [1:0] fb,
    output logic       stall,
    output logic       ex_bubble
);

    // Select encodings for the EX-stage ALU input muxes.
    localparam logic [1:0] SelReg = 2'b00;
    localparam logic [1:0] SelWb  = 2'b01;
    localparam logic [1:0] SelMem = 2'b10;

    // Decoded ID instruction.
    logic [4:0] id_dst;
    logic       id_has_dst;
    logic       id_reads_rs;
    logic       id_reads_rt;
    logic       id_w;
    logic       id_ld;
    logic       id_live;

    // Shadow slots. The WB slot is never a forwarding source (the register
    // file writes before it reads), so only EX and MEM are kept. The load flag
    // only matters while the load sits in EX.
    logic [4:0] ex_d_q, ex_d_d;
    logic       ex_w_q, ex_w_d;
    logic       ex_ld_q, ex_ld_d;
    logic [4:0] mem_d_q;
    logic       mem_w_q;

    logic [1:0] fa_q, fa_d;
    logic [1:0] fb_q, fb_d;
    logic       ex_bubble_q, ex_bubble_d;

    logic [1:0] rs_code;
    logic [1:0] rt_code;
    logic       bubble_in;

    // Opcode decode: destination register and which sources are read.
    always_comb begin
        id_dst      = 5'd0;
        id_has_dst  = 1'b0;
        id_reads_rs = 1'b0;
        id_reads_rt = 1'b0;
        case (id_op)
            ALUOP: begin
                id_dst      = id_rd;
                id_has_dst  = 1'b1;
                id_reads_rs = 1'b1;
                id_reads_rt = 1'b1;
            end
            LWOP, ADDIOP: begin
                id_dst      = id_rt;
                id_has_dst  = 1'b1;
                id_reads_rs = 1'b1;
            end
            SWOP: begin
                id_reads_rs = 1'b1;
                id_reads_rt = 1'b1;
            end
            JALOP: begin
                id_dst     = 5'd31;
                id_has_dst = 1'b1;
            end
            default: begin
                // JOP and unknown opcodes: no destination, no sources.
                id_dst = 5'd0;
            end
        endcase
    end

    // Write/load flags, load-use stall and the EX-bubble decision.
    always_comb begin
        id_live   = id_valid && !id_flush;
        id_w      = id_has_dst && (id_dst != 5'd0) && id_live;
        id_ld     = id_w && (id_op == LWOP);
        stall     = ex_ld_q && id_live &&
                    ((id_reads_rs && (id_rs == ex_d_q)) ||
                     (id_reads_rt && (id_rt == ex_d_q)));
        bubble_in = stall || id_flush;
    end

    // Forward codes: the current EX producer (moving to MEM) beats MEM.
    always_comb begin
        rs_code = SelReg;
        rt_code = SelReg;
        if (id_reads_rs) begin
            if (ex_w_q && (ex_d_q == id_rs)) begin
                rs_code = SelMem;
            end else if (mem_w_q && (mem_d_q == id_rs)) begin
                rs_code = SelWb;
            end
        end
        if (id_reads_rt) begin
            if (ex_w_q && (ex_d_q == id_rt)) begin
                rt_code = SelMem;
            end else if (mem_w_q && (mem_d_q == id_rt)) begin
                rt_code = SelWb;
            end
        end
    end

    // Next EX slot: decoded ID instruction or an inserted bubble.
    always_comb begin
        ex_d_d      = id_dst;
        ex_w_d      = id_w;
        ex_ld_d     = id_ld;
        fa_d        = rs_code;
        fb_d        = rt_code;
        ex_bubble_d = 1'b0;
        if (bubble_in) begin
            ex_d_d      = 5'd0;
            ex_w_d      = 1'b0;
            ex_ld_d     = 1'b0;
            fa_d        = SelReg;
            fb_d        = SelReg;
            ex_bubble_d = 1'b1;
        end
    end

    // Pipeline shadow and registered select outputs; reset fills with bubbles.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ex_d_q      <= 5'd0;
            ex_w_q      <= 1'b0;
            ex_ld_q     <= 1'b0;
            mem_d_q     <= 5'd0;
            mem_w_q     <= 1'b0;
            fa_q        <= SelReg;
            fb_q        <= SelReg;
            ex_bubble_q <= 1'b1;
        end else begin
            mem_d_q     <= ex_d_q;
            mem_w_q     <= ex_w_q;
            ex_d_q      <= ex_d_d;
            ex_w_q      <= ex_w_d;
            ex_ld_q     <= ex_ld_d;
            fa_q        <= fa_d;
            fb_q        <= fb_d;
            ex_bubble_q <= ex_bubble_d;
        end
    end

    // Registered outputs.
    always_comb begin
        fa        = fa_q;
        fb        = fb_q;
        ex_bubble = ex_bubble_q;
    end

endmodule

// File: tb/tb_mips_fwd_ctrl.sv
// Self-checking bench for mips_fwd_ctrl: a hand-derived vector table drives
// one ID instruction per cycle; stall is checked the same cycle and the
// expected EX-stage outputs go through a scoreboard queue, checked after the edge.
module tb_mips_fwd_ctrl;

    localparam logic [5:0] OpAlu  = 6'd0;
    localparam logic [5:0] OpLw   = 6'd35;
    localparam logic [5:0] OpSw   = 6'd43;
    localparam logic [5:0] OpAddi = 6'd8;
    localparam logic [5:0] OpJ    = 6'd2;
    localparam logic [5:0] OpJal  = 6'd3;

    logic       clock;
    logic       reset_n;
    logic       id_valid;
    logic [5:0] id_op;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic [4:0] id_rd;
    logic       id_flush;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       stall;
    logic       ex_bubble;

    int vectors;
    int miscompares;

    typedef struct {
        string      name;
        logic       v;
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic       fl;
        logic       st;   // expected stall while in ID
        logic [1:0] fa;   // expected after the edge
        logic [1:0] fb;
        logic       bub;
    } vec_t;

    typedef struct {
        string      name;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       bub;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    mips_fwd_ctrl dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .id_valid  (id_valid),
        .id_op     (id_op),
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .id_rd     (id_rd),
        .id_flush  (id_flush),
        .fa        (fa),
        .fb        (fb),
        .stall     (stall),
        .ex_bubble (ex_bubble)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mk(input string name, input logic [5:0] op, input logic [4:0] rs,
                                input logic [4:0] rt, input logic [4:0] rd, input logic fl,
                                input logic st, input logic [1:0] efa, input logic [1:0] efb,
                                input logic bub);
        vec_t r;
        r.name = name; r.v = 1'b1; r.op = op; r.rs = rs; r.rt = rt; r.rd = rd; r.fl = fl;
        r.st = st; r.fa = efa; r.fb = efb; r.bub = bub;
        return r;
    endfunction

    function automatic vec_t nop(input string name);
        return mk(name, OpAlu, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    endfunction

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        if (act !== exp) begin
            $display("FAIL %s: got %b, expected %b", name, act, exp);
            miscompares++;
        end
    endtask

    task automatic drive(input vec_t x);
        id_valid = x.v;
        id_op    = x.op;
        id_rs    = x.rs;
        id_rt    = x.rt;
        id_rd    = x.rd;
        id_flush = x.fl;
    endtask

    task automatic apply(input vec_t x);
        exp_t e;
        exp_t got;
        @(negedge clock);
        drive(x);
        #1;
        chk({x.name, ".stall"}, {1'b0, stall}, {1'b0, x.st});
        e.name = x.name; e.fa = x.fa; e.fb = x.fb; e.bub = x.bub;
        sb.push_back(e);
        vectors++;
        @(posedge clock);
        #1;
        got = sb.pop_front();
        chk({got.name, ".fa"}, fa, got.fa);
        chk({got.name, ".fb"}, fb, got.fb);
        chk({got.name, ".ex_bubble"}, {1'b0, ex_bubble}, {1'b0, got.bub});
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        drive(nop("init"));

        // Dependent ALU ops, then gap of one.
        vecs.push_back(mk("add_r3",   OpAlu, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0));
        vecs.push_back(mk("sub_r4",   OpAlu, 5'd5, 5'd3, 5'd4, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0));
        vecs.push_back(nop("nop1"));
        vecs.push_back(nop("nop2"));
        vecs.push_back(mk("add_r3b",  OpAlu, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0));
        vecs.push_back(nop("nop3"));
        vecs.push_back(mk("or_r6",    OpAlu, 5'd3, 5'd7, 5'd6, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0));
        vecs.push_back(nop("nop4"));
        vecs.push_back(nop("nop5"));
        // Load-use: one stall cycle, bubble, then MEM/WB forwarding.
        vecs.push_back(mk("lw_r8",    OpLw,  5'd1, 5'd8, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0));
        vecs.push_back(mk("add_r9_s", OpAlu, 5'd8, 5'd8, 5'd9, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1));
        vecs.push_back(mk("add_r9",   OpAlu, 5'd8, 5'd8, 5'd9, 1'b0, 1'b0, 2'b01, 2'b01, 1'b0));
        vecs.push_back(nop("nop6"));
        vecs.push_back(nop("nop7"));
        // Double producer: youngest wins; addi does not read rt.
        vecs.push_back(mk("addi_r2a", OpAddi, 5'd0, 5'd2, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0));
        vecs.push_back(mk("addi_r2b", OpAddi, 5'd2, 5'd2, 5'd0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0));
        vecs.push_back(mk("add_r5",   OpAlu,  5'd2, 5'd2, 5'd5, 1'b0, 1'b0, 2'b10, 2'b10, 1'b0));
        vecs.push_back(nop("nop8"));
        vecs.push_back(nop("nop9"));
        // r0 is never forwarded.
        vecs.push_back(mk("add_r0",   OpAlu, 5'd1, 5'd1, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0));
        vecs.push_back(mk("add_r4_0", OpAlu, 5'd0, 5'd0, 5'd4, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0));
        // Store reads both operands; jal writes r31; j reads nothing.
        vecs.push_back(mk("add_r10",  OpAlu, 5'd1, 5'd1, 5'd10, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0));
        vecs.push_back(mk("sw_r10",   OpSw,  5'd10, 5'd10, 5'd0, 1'b0, 1'b0, 2'b10, 2'b10, 1'b0));
        vecs.push_back(mk("jal",      OpJal, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0));
        vecs.push_back(mk("add_r31",  OpAlu, 5'd31, 5'd0, 5'd1, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0));
        vecs.push_back(mk("j",        OpJ,   5'd1, 5'd1, 5'd1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0));
        vecs.push_back(nop("nop10"));
        vecs.push_back(nop("nop11"));
        // Flush overrides a load-use stall.
        vecs.push_back(mk("lw_r8f",   OpLw,  5'd1, 5'd8, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0));
        vecs.push_back(mk("add_fl",   OpAlu, 5'd8, 5'd8, 5'd9, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1));
        vecs.push_back(nop("nop12"));
        vecs.push_back(nop("nop13"));
        vecs.push_back(mk("lw_r8r",   OpLw,  5'd1, 5'd8, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0));

        // Reset state.
        #12;
        vectors++;
        chk("reset.stall", {1'b0, stall}, 2'b00);
        chk("reset.fa", fa, 2'b00);
        chk("reset.fb", fb, 2'b00);
        chk("reset.ex_bubble", {1'b0, ex_bubble}, 2'b01);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
        end

        // Reset asserted while stalled on the load just issued.
        @(negedge clock);
        drive(mk("add_rst", OpAlu, 5'd8, 5'd8, 5'd9, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0));
        #1;
        vectors++;
        chk("rst_mid.stall_before", {1'b0, stall}, 2'b01);
        reset_n = 1'b0;
        #1;
        chk("rst_mid.stall", {1'b0, stall}, 2'b00);
        chk("rst_mid.fa", fa, 2'b00);
        chk("rst_mid.fb", fb, 2'b00);
        chk("rst_mid.ex_bubble", {1'b0, ex_bubble}, 2'b01);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        vectors++;
        chk("post_rst.stall", {1'b0, stall}, 2'b00);
        @(posedge clock);
        #1;
        chk("post_rst.fa", fa, 2'b00);
        chk("post_rst.fb", fb, 2'b00);
        chk("post_rst.ex_bubble", {1'b0, ex_bubble}, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
